// File: rtl/noc_params.sv
// Shared NoC router sizing and port naming used by the switch allocator.
package noc_params;

    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 2;
    localparam int VC_SIZE   = $clog2(VC_NUM);
    localparam int PORT_SIZE = $clog2(PORT_NUM);

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter over N requesters; the search starts at the registered
// pointer, which moves past the winner only when the caller enables it.
module round_robin_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          adv_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand;
    logic          hit;
    logic [IW-1:0] sel;

    always_comb begin
        hit  = 1'b0;
        sel  = '0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (!hit && req_i[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i && hit) begin
            ptr_d = (sel == IW'(N - 1)) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign valid_o = hit;
    assign idx_o   = sel;

endmodule

// File: rtl/switch_allocator.sv
// Two-stage separable switch allocator: per-input VC arbitration, then
// per-output input arbitration; grants are registered for one cycle of latency.
module switch_allocator
    import noc_params::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]   request_i,
    input  port_t                             out_port_i      [PORT_NUM][VC_NUM],
    input  logic [VC_SIZE-1:0]                downstream_vc_i [PORT_NUM][VC_NUM],
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]   on_off_i,
    output logic [PORT_NUM-1:0]               valid_sel_o,
    output logic [VC_SIZE-1:0]                vc_sel_o        [PORT_NUM],
    output port_t                             xbar_sel_o      [PORT_NUM],
    output logic [PORT_NUM-1:0]               valid_flit_o
);

    logic [PORT_NUM-1:0][VC_NUM-1:0]   eligible;
    logic [PORT_NUM-1:0]               in_valid;
    logic [PORT_NUM-1:0]               in_won;
    logic [VC_SIZE-1:0]                in_idx    [PORT_NUM];
    port_t                             in_target [PORT_NUM];
    logic [PORT_NUM-1:0][PORT_NUM-1:0] out_req;
    logic [PORT_NUM-1:0]               out_valid;
    logic [PORT_SIZE-1:0]              out_idx   [PORT_NUM];

    logic [PORT_NUM-1:0]  valid_sel_q,  valid_sel_d;
    logic [PORT_NUM-1:0]  valid_flit_q, valid_flit_d;
    logic [VC_SIZE-1:0]   vc_sel_q   [PORT_NUM];
    logic [VC_SIZE-1:0]   vc_sel_d   [PORT_NUM];
    port_t                xbar_sel_q [PORT_NUM];
    port_t                xbar_sel_d [PORT_NUM];

    // A request is only eligible when the downstream VC it targets has space.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (request_i[i][v] && (int'(out_port_i[i][v]) < PORT_NUM)) begin
                    eligible[i][v] = on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]];
                end
            end
        end
    end

    for (genvar g = 0; g < PORT_NUM; g++) begin : g_in_arb
        round_robin_arbiter #(.N(VC_NUM)) u_in_arb (
            .clk     (clk),
            .rst     (rst),
            .req_i   (eligible[g]),
            .adv_i   (in_won[g]),
            .valid_o (in_valid[g]),
            .idx_o   (in_idx[g])
        );
    end

    always_comb begin
        out_req = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            in_target[i] = out_port_i[i][in_idx[i]];
            for (int o = 0; o < PORT_NUM; o++) begin
                out_req[o][i] = in_valid[i] && (int'(in_target[i]) == o);
            end
        end
    end

    for (genvar g = 0; g < PORT_NUM; g++) begin : g_out_arb
        round_robin_arbiter #(.N(PORT_NUM)) u_out_arb (
            .clk     (clk),
            .rst     (rst),
            .req_i   (out_req[g]),
            .adv_i   (out_valid[g]),
            .valid_o (out_valid[g]),
            .idx_o   (out_idx[g])
        );
    end

    // Only inputs whose VC survived the output stage move their VC pointer.
    always_comb begin
        in_won = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            if (out_valid[o]) begin
                in_won[out_idx[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        valid_sel_d  = in_won;
        valid_flit_d = out_valid;
        for (int i = 0; i < PORT_NUM; i++) begin
            vc_sel_d[i] = in_won[i] ? in_idx[i] : vc_sel_q[i];
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            xbar_sel_d[o] = out_valid[o] ? port_t'(out_idx[o]) : xbar_sel_q[o];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_sel_q  <= '0;
            valid_flit_q <= '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                vc_sel_q[i]   <= '0;
                xbar_sel_q[i] <= LOCAL;
            end
        end else begin
            valid_sel_q  <= valid_sel_d;
            valid_flit_q <= valid_flit_d;
            for (int i = 0; i < PORT_NUM; i++) begin
                vc_sel_q[i]   <= vc_sel_d[i];
                xbar_sel_q[i] <= xbar_sel_d[i];
            end
        end
    end

    assign valid_sel_o  = valid_sel_q;
    assign valid_flit_o = valid_flit_q;
    assign vc_sel_o     = vc_sel_q;
    assign xbar_sel_o   = xbar_sel_q;

endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 SHALL have no module parameters; all sizing comes from package noc_params (PORT_NUM=5, VC_NUM, VC_SIZE, PORT_SIZE, port_t).
REQ-002 SHALL have one clock; reset is synchronous and active-high (ports clk, rst).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 request_i  input  [PORT_NUM][VC_NUM]  input VC holds a flit and has completed VC allocation.
REQ-006 out_port_i  input  port_t [PORT_NUM][VC_NUM]  output port computed for each input VC.
REQ-007 downstream_vc_i  input  [PORT_NUM][VC_NUM][VC_SIZE]  downstream VC assigned to each input VC.
REQ-008 on_off_i  input  [PORT_NUM][VC_NUM]  per output port, per downstream VC: 1 = downstream can accept a flit.
REQ-009 valid_sel_o  output  [PORT_NUM]  read strobe to input port i this cycle.
REQ-010 vc_sel_o  output  [PORT_NUM][VC_SIZE]  VC of input port i to read; meaningful only when valid_sel_o[i]=1.
REQ-011 xbar_sel_o  output  port_t [PORT_NUM]  input port switched onto output o.
REQ-012 valid_flit_o  output  [PORT_NUM]  output o carries a valid flit next cycle.

Function
REQ-013 Eligibility: VC v of input i SHALL be eligible iff request_i[i][v] & on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]].
REQ-014 Input stage: per input i, a round-robin arbiter SHALL pick at most one eligible VC, starting the search at in_ptr[i].
REQ-015 Output stage: per output o, a round-robin arbiter SHALL pick at most one input among the input-stage winners with out_port=o, starting the search at out_ptr[o].
REQ-016 Grants SHALL be registered: requests sampled at edge N appear on the outputs after edge N+1, i.e. a 1-cycle latency.
REQ-017 After each edge, valid_sel_o[i]=1 and vc_sel_o[i]=v iff input i's winner v was granted by its output; valid_flit_o[o]=1 and xbar_sel_o[o]=i for that same grant.
REQ-018 Per cycle, each input port and each output port SHALL be granted at most once.
REQ-019 in_ptr[i] SHALL advance to (winner+1) mod VC_NUM only when input i wins the output stage, and SHALL hold otherwise.
REQ-020 out_ptr[o] SHALL advance to (granted input+1) mod PORT_NUM on a grant, and SHALL hold otherwise.
REQ-021 Pointer wrap: from VC_NUM-1 to 0 and from PORT_NUM-1 to 0; pointers never hold out-of-range values.
REQ-022 No eligible requests: all valid outputs 0 after the edge, pointers hold, vc_sel_o/xbar_sel_o hold their last values.
REQ-023 on_off_i low for the targeted downstream VC SHALL block that request even if it is the only one; no grant is issued.
REQ-024 Multiple inputs targeting the same output: exactly one grant; the losers keep their input-stage pointer and retry next cycle.
REQ-025 The block is purely combinational between registers apart from the pointer and grant registers; no packet locking is applied, since VC allocation already guarantees flit order.

Reset
REQ-026 On rst=1 at an edge: valid_sel_o=0, valid_flit_o=0, vc_sel_o=0, xbar_sel_o=0 (LOCAL), all in_ptr=0, all out_ptr=0.
REQ-027 Reset asserted mid-operation SHALL clear grants at that edge regardless of requests; the first grant can appear on the edge after rst deasserts.

Structure
REQ-028 PORT_NUM, VC_NUM, VC_SIZE, PORT_SIZE and port_t SHALL live in noc_params; no new package constants are required.
REQ-029 SHALL instantiate a parameterised sub-module round_robin_arbiter (N requesters, registered pointer, pointer-advance enable input): PORT_NUM instances of N=VC_NUM and PORT_NUM instances of N=PORT_NUM.

Verification (VC_NUM=2, PORT_NUM=5)
REQ-030 Single request: rst released; request_i[NORTH][1]=1, out_port=EAST, on_off[EAST][dvc]=1 at edge N -> after edge N+1: valid_sel_o[NORTH]=1, vc_sel_o[NORTH]=1, valid_flit_o[EAST]=1, xbar_sel_o[EAST]=NORTH; all other valids 0.
REQ-031 Output conflict: LOCAL and WEST both target SOUTH, held for 4 cycles -> grants alternate LOCAL, WEST, LOCAL, WEST.
REQ-032 Input VC round-robin: input LOCAL, VC0->NORTH and VC1->EAST held -> vc_sel_o[LOCAL] alternates 0,1,0,1; at most one grant per cycle on LOCAL.
REQ-033 Backpressure: on_off[EAST][0]=0 with the only request targeting EAST/VC0 -> no grants for 3 cycles; raise on_off -> grant on the following edge.
REQ-034 Reset mid-run: rst=1 during the REQ-031 traffic -> all outputs 0 after that edge, pointers 0; after rst=0 the first grant goes to LOCAL.
REQ-035 Bench SHALL check REQ-018 (one grant per input and per output) every cycle under 1000 cycles of random requests and on_off.
